imem_port_arbiter: RTL and testbench

- Shares one single-port, synchronous-read instruction memory between two requesters: the CPU fetch port (read-only) and the program loader/debug port (read/write).
- Sits between the fetch stage, the boot loader and the instruction memory array.
- Applies fixed loader priority with a starvation guard for fetch.
- Routes each one-cycle-latency read response back to the requester that issued it, and flags misaligned or out-of-range accesses.

---
 rtl/imem_port_arbiter_if.sv | 53 +++++
 rtl/imem_port_arbiter.sv | 104 ++++++++++
 tb/tb_imem_port_arbiter.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_port_arbiter_if.sv
// imem_port_arbiter_if
//   Bundles the fetch port, the loader port and the instruction-memory port
//   of imem_port_arbiter.
//
//   Handshake (both requester ports): x_req is held high with a stable
//   address/data until the cycle x_gnt=1; a transfer happens in every cycle
//   where x_req & x_gnt. Exactly one cycle later x_rvalid=1 pulses for that
//   transfer, with x_err and x_rdata qualified by it. There is no backpressure
//   on responses.
//
//   Modports:
//     slave  - the arbiter side (takes requests, drives grants/responses/memory)
//     master - the environment side (requesters and memory array)
interface imem_port_arbiter_if #(
  parameter int AW = 8
);
  // fetch port
  logic          f_req;
  logic [31:0]   f_addr;
  logic          f_gnt;
  logic          f_rvalid;
  logic [31:0]   f_rdata;
  logic          f_err;
  // loader / debug port
  logic          l_req;
  logic          l_we;
  logic [31:0]   l_addr;
  logic [31:0]   l_wdata;
  logic          l_gnt;
  logic          l_rvalid;
  logic [31:0]   l_rdata;
  logic          l_err;
  // memory port
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  modport slave (
    input  f_req, f_addr, l_req, l_we, l_addr, l_wdata, mem_rdata,
    output f_gnt, f_rvalid, f_rdata, f_err,
    output l_gnt, l_rvalid, l_rdata, l_err,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output f_req, f_addr, l_req, l_we, l_addr, l_wdata, mem_rdata,
    input  f_gnt, f_rvalid, f_rdata, f_err,
    input  l_gnt, l_rvalid, l_rdata, l_err,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter
//   Shares a single-port, synchronous-read instruction memory between the CPU
//   fetch port (read-only) and the loader/debug port (read/write). The loader
//   has fixed priority, but after MAX_LDR_BURST consecutive loader grants
//   while fetch is waiting, fetch is forced through. Each access is checked
//   for alignment and range in its grant cycle; an erroring access is still
//   granted but does not touch memory. Responses come back one cycle after
//   the grant on the owner's port only.
//
//   Ports:
//     clk, rst    - clock, synchronous active-high reset
//     bus         - imem_port_arbiter_if.slave (fetch, loader, memory signals)
//     dbg_streak  - current loader-streak counter (state visibility)
module imem_port_arbiter #(
  parameter int DEPTH         = 256,
  parameter int AW            = 8,
  parameter int MAX_LDR_BURST = 4
) (
  input  logic                clk,
  input  logic                rst,
  imem_port_arbiter_if.slave  bus,
  output logic [3:0]          dbg_streak
);

  // First byte address past the end of the array; anything at or above it
  // is out of range.
  localparam logic [32:0] BYTE_LIMIT = 33'(DEPTH) << 2;

  logic [3:0]  streak_q, streak_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_ldr_q, rsp_ldr_d;   // 1: response belongs to the loader
  logic        rsp_err_q, rsp_err_d;
  logic        rsp_we_q, rsp_we_d;

  logic        starve;
  logic        f_gnt_c, l_gnt_c, any_gnt;
  logic [31:0] sel_addr;
  logic        acc_err;
  logic        rsp_live, rsp_good_rd;

  always_comb begin
    starve  = (streak_q == 4'(MAX_LDR_BURST));
    // Loader wins ties unless fetch has been starved long enough.
    l_gnt_c = !rst && bus.l_req && !(bus.f_req && starve);
    f_gnt_c = !rst && bus.f_req && !l_gnt_c;
    any_gnt = f_gnt_c || l_gnt_c;

    sel_addr = l_gnt_c ? bus.l_addr : bus.f_addr;
    acc_err  = (sel_addr[1:0] != 2'b00) || ({1'b0, sel_addr} >= BYTE_LIMIT);

    // Streak counts loader grants only while fetch is actually waiting.
    streak_d = streak_q;
    if (!bus.f_req || f_gnt_c) begin
      streak_d = 4'd0;
    end else if (l_gnt_c) begin
      streak_d = streak_q + 4'd1;
    end

    rsp_valid_d = any_gnt;
    rsp_ldr_d   = l_gnt_c;
    rsp_err_d   = acc_err;
    rsp_we_d    = l_gnt_c && bus.l_we;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      streak_q    <= 4'd0;
      rsp_valid_q <= 1'b0;
      rsp_ldr_q   <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_we_q    <= 1'b0;
    end else begin
      streak_q    <= streak_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_ldr_q   <= rsp_ldr_d;
      rsp_err_q   <= rsp_err_d;
      rsp_we_q    <= rsp_we_d;
    end
  end

  // Grants and memory drive
  assign bus.f_gnt     = f_gnt_c;
  assign bus.l_gnt     = l_gnt_c;
  assign bus.mem_en    = any_gnt && !acc_err;
  assign bus.mem_we    = l_gnt_c && bus.l_we;
  assign bus.mem_addr  = any_gnt ? sel_addr[AW+1:2] : '0;
  assign bus.mem_wdata = l_gnt_c ? bus.l_wdata : 32'd0;

  // Responses. Gating with rst drops a response whose grant happened the
  // cycle before reset was raised.
  assign rsp_live    = rsp_valid_q && !rst;
  assign rsp_good_rd = rsp_live && !rsp_err_q && !rsp_we_q;

  assign bus.f_rvalid = rsp_live && !rsp_ldr_q;
  assign bus.f_err    = rsp_live && !rsp_ldr_q && rsp_err_q;
  assign bus.f_rdata  = (rsp_good_rd && !rsp_ldr_q) ? bus.mem_rdata : 32'd0;

  assign bus.l_rvalid = rsp_live && rsp_ldr_q;
  assign bus.l_err    = rsp_live && rsp_ldr_q && rsp_err_q;
  assign bus.l_rdata  = (rsp_good_rd && rsp_ldr_q) ? bus.mem_rdata : 32'd0;

  assign dbg_streak = streak_q;

endmodule

// File: tb/tb_imem_port_arbiter.sv
module tb_imem_port_arbiter;
  localparam int DEPTH = 256;
  localparam int AW    = 8;
  localparam int MAXB  = 4;

  logic       clk;
  logic       rst;
  logic [3:0] dbg_streak;

  imem_port_arbiter_if #(.AW(AW)) bus();

  imem_port_arbiter #(.DEPTH(DEPTH), .AW(AW), .MAX_LDR_BURST(MAXB)) dut (
    .clk(clk), .rst(rst), .bus(bus), .dbg_streak(dbg_streak)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory array (environment) ----------------
  logic [31:0] mem_arr [DEPTH];
  logic [31:0] mem_rd_q;
  assign bus.mem_rdata = mem_rd_q;

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem_arr[bus.mem_addr] <= bus.mem_wdata;
      else            mem_rd_q <= mem_arr[bus.mem_addr];
    end
  end

  function automatic logic [31:0] preload(input int i);
    if (i == 2) return 32'h0083_2383;
    return 32'hA500_0000 | 32'(i);
  endfunction

  // ---------------- counters ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Loader wins unless fetch has already watched MAXB loader grants in a row;
  // every granted access yields one response on its owner's port next cycle.
  logic [31:0] shadow [DEPTH];
  int          m_run;            // loader grants in a row while fetch waited
  int          m_who;            // 0 none, 1 fetch, 2 loader
  bit          m_err;
  int          m_word;
  bit          p_valid, p_ldr, p_err;
  logic [31:0] p_data;

  // current inputs
  bit          d_rst, d_f_req, d_l_req, d_l_we;
  logic [31:0] d_f_addr, d_l_addr, d_l_wdata;

  task automatic model_eval_check();
    logic [31:0] a;
    bit live;
    if (d_rst) m_who = 0;
    else if (d_l_req && !(d_f_req && m_run >= MAXB)) m_who = 2;
    else if (d_f_req) m_who = 1;
    else m_who = 0;
    a      = (m_who == 2) ? d_l_addr : d_f_addr;
    m_err  = (a % 4 != 0) || (longint'(a) >= longint'(DEPTH) * 4);
    m_word = int'((a / 4) % DEPTH);

    chk("m_f_gnt", 32'(bus.f_gnt), 32'(m_who == 1));
    chk("m_l_gnt", 32'(bus.l_gnt), 32'(m_who == 2));
    chk("m_mem_en", 32'(bus.mem_en), 32'(m_who != 0 && !m_err));
    chk("m_mem_we", 32'(bus.mem_we), 32'(m_who == 2 && d_l_we));
    chk("m_mem_addr", 32'(bus.mem_addr), (m_who != 0) ? 32'(m_word) : 32'd0);
    chk("m_mem_wdata", bus.mem_wdata, (m_who == 2) ? d_l_wdata : 32'd0);
    chk("m_streak", 32'(dbg_streak), 32'(m_run));

    live = p_valid && !d_rst;
    chk("m_f_rvalid", 32'(bus.f_rvalid), 32'(live && !p_ldr));
    chk("m_f_err",    32'(bus.f_err),    32'(live && !p_ldr && p_err));
    chk("m_f_rdata",  bus.f_rdata,       (live && !p_ldr) ? p_data : 32'd0);
    chk("m_l_rvalid", 32'(bus.l_rvalid), 32'(live && p_ldr));
    chk("m_l_err",    32'(bus.l_err),    32'(live && p_ldr && p_err));
    chk("m_l_rdata",  bus.l_rdata,       (live && p_ldr) ? p_data : 32'd0);
  endtask

  task automatic model_commit();
    bit wr;
    if (d_rst) begin
      m_run   = 0;
      p_valid = 0;
      return;
    end
    m_run   = (m_who == 2 && d_f_req) ? m_run + 1 : 0;
    wr      = (m_who == 2) && d_l_we;
    p_valid = (m_who != 0);
    p_ldr   = (m_who == 2);
    p_err   = m_err;
    p_data  = (m_err || wr) ? 32'd0 : shadow[m_word];
    if (m_who == 2 && wr && !m_err) shadow[m_word] = d_l_wdata;
  endtask

  // ---------------- driver ----------------
  // Inputs change on the falling edge; outputs are checked 1ns later, well
  // away from the rising edge the DUT and memory act on.
  task automatic drive(input bit r, input bit fq, input logic [31:0] fa,
                       input bit lq, input bit lw, input logic [31:0] la,
                       input logic [31:0] ld);
    @(negedge clk);
    d_rst = r; d_f_req = fq; d_f_addr = fa;
    d_l_req = lq; d_l_we = lw; d_l_addr = la; d_l_wdata = ld;
    rst = r;
    bus.f_req = fq; bus.f_addr = fa;
    bus.l_req = lq; bus.l_we = lw; bus.l_addr = la; bus.l_wdata = ld;
    #1;
  endtask

  task automatic finish_cycle();
    @(posedge clk);
    model_commit();
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    bit          rst;
    bit          f_req;
    logic [31:0] f_addr;
    bit          l_req;
    bit          l_we;
    logic [31:0] l_addr;
    logic [31:0] l_wdata;
    logic [1:0]  gnt;     // 01 fetch, 10 loader
    bit          en;
    bit          we;
    logic [7:0]  maddr;
    bit          f_rv;
    bit          l_rv;
    bit          err;
    logic [31:0] rdata;
  } vec_t;

  localparam logic [1:0] GN = 2'b00, GF = 2'b01, GL = 2'b10;

  vec_t vecs [25];

  function automatic vec_t mk(bit r, bit fq, logic [31:0] fa, bit lq, bit lw,
                              logic [31:0] la, logic [31:0] ld, logic [1:0] g,
                              bit en, bit we, logic [7:0] ma, bit frv, bit lrv,
                              bit er, logic [31:0] rd);
    vec_t v;
    v.rst = r; v.f_req = fq; v.f_addr = fa; v.l_req = lq; v.l_we = lw;
    v.l_addr = la; v.l_wdata = ld; v.gnt = g; v.en = en; v.we = we;
    v.maddr = ma; v.f_rv = frv; v.l_rv = lrv; v.err = er; v.rdata = rd;
    return v;
  endfunction

  task automatic check_vec(input int i, input vec_t v);
    string s;
    s = $sformatf("v%0d", i);
    chk({s, "_f_gnt"},    32'(bus.f_gnt),    32'(v.gnt[0]));
    chk({s, "_l_gnt"},    32'(bus.l_gnt),    32'(v.gnt[1]));
    chk({s, "_mem_en"},   32'(bus.mem_en),   32'(v.en));
    chk({s, "_mem_we"},   32'(bus.mem_we),   32'(v.we));
    chk({s, "_mem_addr"}, 32'(bus.mem_addr), 32'(v.maddr));
    chk({s, "_f_rvalid"}, 32'(bus.f_rvalid), 32'(v.f_rv));
    chk({s, "_f_err"},    32'(bus.f_err),    32'(v.f_rv && v.err));
    chk({s, "_f_rdata"},  bus.f_rdata,       v.f_rv ? v.rdata : 32'd0);
    chk({s, "_l_rvalid"}, 32'(bus.l_rvalid), 32'(v.l_rv));
    chk({s, "_l_err"},    32'(bus.l_err),    32'(v.l_rv && v.err));
    chk({s, "_l_rdata"},  bus.l_rdata,       v.l_rv ? v.rdata : 32'd0);
  endtask

  function automatic logic [31:0] rnd_addr();
    int r;
    r = $urandom_range(0, 15);
    if (r == 0) return 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
    if (r == 1) return 32'(DEPTH * 4) + 32'($urandom_range(0, 4095) * 4);
    return 32'($urandom_range(0, DEPTH - 1) * 4);
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_arr[i] = preload(i);
      shadow[i]  = preload(i);
    end
    mem_rd_q = 32'd0;
    m_run = 0; p_valid = 0; p_ldr = 0; p_err = 0; p_data = 0;
    rst = 1'b1;
    bus.f_req = 0; bus.f_addr = 0; bus.l_req = 0; bus.l_we = 0;
    bus.l_addr = 0; bus.l_wdata = 0;

    //                 rst fq fa       lq lw la     ld            gnt en we ma   frv lrv er rdata
    vecs[0]  = mk(1, 0, 32'h0,   0, 0, 32'h0,  32'h0,        GN, 0, 0, 8'd0, 0, 0, 0, 32'h0);
    vecs[1]  = mk(0, 1, 32'h8,   0, 0, 32'h0,  32'h0,        GF, 1, 0, 8'd2, 0, 0, 0, 32'h0);
    vecs[2]  = mk(0, 0, 32'h0,   0, 0, 32'h0,  32'h0,        GN, 0, 0, 8'd0, 1, 0, 0, 32'h0083_2383);
    vecs[3]  = mk(0, 0, 32'h0,   1, 1, 32'h14, 32'h0062_E233, GL, 1, 1, 8'd5, 0, 0, 0, 32'h0);
    vecs[4]  = mk(0, 1, 32'h14,  0, 0, 32'h0,  32'h0,        GF, 1, 0, 8'd5, 0, 1, 0, 32'h0);
    vecs[5]  = mk(0, 0, 32'h0,   0, 0, 32'h0,  32'h0,        GN, 0, 0, 8'd0, 1, 0, 0, 32'h0062_E233);
    vecs[6]  = mk(0, 1, 32'h6,   0, 0, 32'h0,  32'h0,        GF, 0, 0, 8'd1, 0, 0, 0, 32'h0);
    vecs[7]  = mk(0, 1, 32'h400, 0, 0, 32'h0,  32'h0,        GF, 0, 0, 8'd0, 1, 0, 1, 32'h0);
    vecs[8]  = mk(0, 0, 32'h0,   0, 0, 32'h0,  32'h0,        GN, 0, 0, 8'd0, 1, 0, 1, 32'h0);
    vecs[9]  = mk(0, 0, 32'h0,   1, 0, 32'h0,  32'h0,        GL, 1, 0, 8'd0, 0, 0, 0, 32'h0);
    vecs[10] = mk(1, 0, 32'h0,   0, 0, 32'h0,  32'h0,        GN, 0, 0, 8'd0, 0, 0, 0, 32'h0);
    vecs[11] = mk(0, 0, 32'h0,   0, 0, 32'h0,  32'h0,        GN, 0, 0, 8'd0, 0, 0, 0, 32'h0);
    vecs[12] = mk(1, 1, 32'h0,   1, 0, 32'h4,  32'h0,        GN, 0, 0, 8'd0, 0, 0, 0, 32'h0);
    vecs[13] = mk(0, 0, 32'h0,   0, 0, 32'h0,  32'h0,        GN, 0, 0, 8'd0, 0, 0, 0, 32'h0);
    // both requesting: L,L,L,L,F,L,L,L,L,F
    vecs[14] = mk(0, 1, 32'h0,   1, 0, 32'h4,  32'h0,        GL, 1, 0, 8'd1, 0, 0, 0, 32'h0);
    for (int i = 15; i <= 17; i++)
      vecs[i] = mk(0, 1, 32'h0, 1, 0, 32'h4, 32'h0,         GL, 1, 0, 8'd1, 0, 1, 0, 32'hA500_0001);
    vecs[18] = mk(0, 1, 32'h0,   1, 0, 32'h4,  32'h0,        GF, 1, 0, 8'd0, 0, 1, 0, 32'hA500_0001);
    vecs[19] = mk(0, 1, 32'h0,   1, 0, 32'h4,  32'h0,        GL, 1, 0, 8'd1, 1, 0, 0, 32'hA500_0000);
    for (int i = 20; i <= 22; i++)
      vecs[i] = mk(0, 1, 32'h0, 1, 0, 32'h4, 32'h0,         GL, 1, 0, 8'd1, 0, 1, 0, 32'hA500_0001);
    vecs[23] = mk(0, 1, 32'h0,   1, 0, 32'h4,  32'h0,        GF, 1, 0, 8'd0, 0, 1, 0, 32'hA500_0001);
    vecs[24] = mk(0, 0, 32'h0,   0, 0, 32'h0,  32'h0,        GN, 0, 0, 8'd0, 1, 0, 0, 32'hA500_0000);

    for (int i = 0; i < 25; i++) begin
      drive(vecs[i].rst, vecs[i].f_req, vecs[i].f_addr, vecs[i].l_req,
            vecs[i].l_we, vecs[i].l_addr, vecs[i].l_wdata);
      check_vec(i, vecs[i]);
      model_eval_check();
      if (i == 11) chk("streak_after_reset", 32'(dbg_streak), 32'd0);
      finish_cycle();
    end

    // Alternating single-cycle fetch and loader reads.
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) drive(0, 1, 32'(i * 4), 0, 0, 32'h0, 32'h0);
      else            drive(0, 0, 32'h0, 1, 0, 32'(i * 4), 32'h0);
      model_eval_check();
      finish_cycle();
    end

    // Randomised traffic, including drops, errors, writes and resets.
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0, rnd_addr(),
            $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, rnd_addr(),
            $urandom);
      model_eval_check();
      finish_cycle();
    end

    drive(0, 0, 32'h0, 0, 0, 32'h0, 32'h0);
    model_eval_check();
    finish_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
